fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter sequencer and fetch controller for the lab CPU. Each cycle it drives a word address and enable into the combinational-read instruction memory (32-bit words, byte address >> 2). It registers the returned instruction toward decode through a valid/ready handshake, and it accepts branch redirects from execute. It sits between the instruction memory and the decode stage and owns the only PC register in the design.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset (word aligned)
- MEM_WORDS, 16, number of valid instruction-memory words; fetches at word index >= MEM_WORDS halt the sequencer
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_addr  output  32  byte address to instruction memory; always equals the current PC
- imem_en  output  1  read enable to instruction memory
- imem_instr  input  32  instruction word returned combinationally for imem_addr
- out_valid  output  1  out_instr/out_pc hold a fetched instruction
- out_ready  input  1  decode accepts the instruction this cycle
- out_instr  output  32  registered instruction
- out_pc  output  32  byte address of out_instr
- redirect_valid  input  1  single-cycle branch/jump request
- redirect_target  input  32  new PC; bits [1:0] are ignored (forced to 0)
- halted  output  1  sequencer is in HALTED
- fetch_count  output  32  number of accepted handshakes, saturating

## Operation
- States: IDLE, RUN, HALTED. IDLE is entered only by reset and lasts exactly one cycle, then goes to RUN unconditionally (redirect in IDLE still loads the PC).
- fetch_ok = (state == RUN) && (!out_valid || out_ready) && !redirect_valid.
- imem_en = fetch_ok (combinational). imem_addr = pc at all times.
- On an edge with fetch_ok and pc[31:2] < MEM_WORDS:
  - out_instr <= imem_instr, out_pc <= pc, out_valid <= 1, pc <= pc + 4.
- On an edge with fetch_ok and pc[31:2] >= MEM_WORDS:
  - no load; out_valid <= 0; state <= HALTED.
- On an edge with out_valid && out_ready and no new load: out_valid <= 0.
- If out_valid && !out_ready (stall), all of out_instr, out_pc, out_valid and pc hold.
- Redirect has highest priority, from any state except during reset:
  - pc <= {redirect_target[31:2], 2'b00}; out_valid <= 0 (pending instruction flushed).
  - State becomes RUN if the target word index < MEM_WORDS, else HALTED.
- HALTED: imem_en = 0, halted = 1, out_valid = 0. Left only by reset or by an in-range redirect.
- fetch_count increments on every edge where out_valid && out_ready. This includes an edge that also carries a redirect, because the current instruction is accepted and then flushing applies to later content. It saturates at 32'hFFFF_FFFF.
- PC arithmetic is 32-bit modulo. Wrap-around cannot produce a fetch because out-of-range addresses halt first.

## Timing
- Reset values: state IDLE, pc = RESET_PC, imem_addr = RESET_PC, imem_en = 0, out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, fetch_count = 0.
- Asserting reset mid-operation clears all of the above immediately, without waiting for a clock edge.
- First instruction: edge 1 after reset deassert moves IDLE -> RUN; edge 2 raises out_valid with word 0.
- Throughput: one instruction per cycle while out_ready = 1.
- Redirect penalty: redirect sampled at edge N makes out_valid = 0 after N. The target instruction is valid after edge N+1, so there is exactly one bubble.
- The stall response is the same cycle: fetch_ok falls combinationally when out_valid && !out_ready.
- halted rises on the edge that detects the out-of-range fetch. An instruction accepted on that same edge is counted.

## Test plan
- Reset and straight-line fetch: MEM_WORDS=4, out_ready=1, release reset. Required: out_valid first high after edge 2 with out_pc=0, then out_pc 4, 8, 12. Next edge: halted=1, out_valid=0, fetch_count=4.
- Backpressure: hold out_ready=0 for 3 cycles while out_pc=4. Required: out_pc/out_instr stay at 4 and imem_en=0 throughout. After release, out_pc=8 on the next edge.
- Redirect: pulse redirect_valid with redirect_target=32'h0000_000E while out_pc=4 and out_ready=1. Required: fetch_count increments, out_valid=0 for one cycle, then out_pc=32'h0000_000C.
- Redirect out of HALTED: after the halt in scenario 1, redirect to 32'h4. Required: halted=0 on the next edge, then out_pc=4 valid one edge later. Redirecting to 32'h40 with MEM_WORDS=16 instead keeps halted=1.
- Asynchronous reset mid-stream: assert reset between edges while out_valid=1. Required: out_valid=0, pc=RESET_PC and fetch_count=0 before the next rising edge.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory port, decode handshake, redirect input and status.
// The master modport is the sequencer; the slave modport is the memory/decode/execute side.
interface fetch_sequencer_if;
   logic [31:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        halted;
   logic [31:0] fetch_count;

   modport master (
      output imem_addr, imem_en, out_valid, out_instr, out_pc, halted, fetch_count,
      input  imem_instr, out_ready, redirect_valid, redirect_target
   );

   modport slave (
      input  imem_addr, imem_en, out_valid, out_instr, out_pc, halted, fetch_count,
      output imem_instr, out_ready, redirect_valid, redirect_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch controller: reads the combinational instruction memory and
// hands registered instructions to decode over valid/ready, with branch redirects.
//
// state  | meaning
// IDLE   | one cycle after reset; a redirect here still loads the PC
// RUN    | fetching whenever the output slot is free
// HALTED | PC left the memory range; only reset or an in-range redirect leaves
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 16
) (
   input  logic               clk,
   input  logic               reset,
   fetch_sequencer_if.master  bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

   localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] out_instr_q, out_pc_q, fetch_count_q;
   logic        out_valid_q;
   logic [31:0] target_aligned;
   logic        pc_in_range, target_in_range, fetch_ok, accept;

   assign target_aligned  = bus.redirect_target & ~32'h3;
   assign pc_in_range     = pc[31:2] < MEM_LIMIT;
   assign target_in_range = target_aligned[31:2] < MEM_LIMIT;
   assign accept          = out_valid_q && bus.out_ready;
   assign fetch_ok        = (state == RUN) && (!out_valid_q || bus.out_ready) && !bus.redirect_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = RUN;
         RUN: begin
            if (bus.redirect_valid)
               state_nxt = target_in_range ? RUN : HALTED;
            else if (fetch_ok && !pc_in_range)
               state_nxt = HALTED;
         end
         HALTED: begin
            if (bus.redirect_valid && target_in_range)
               state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.imem_en = fetch_ok;
      bus.halted  = (state == HALTED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else if (bus.redirect_valid) begin
         pc          <= target_aligned;
         out_valid_q <= 1'b0;
      end else if (fetch_ok && pc_in_range) begin
         out_instr_q <= bus.imem_instr;
         out_pc_q    <= pc;
         out_valid_q <= 1'b1;
         pc          <= pc + 32'd4;
      end else if (fetch_ok || accept) begin
         out_valid_q <= 1'b0;
      end
   end

   // A redirect edge still counts the handshake it carries; flushing hits later content.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fetch_count_q <= '0;
      else if (accept && fetch_count_q != 32'hFFFF_FFFF)
         fetch_count_q <= fetch_count_q + 32'd1;
   end

   assign bus.imem_addr   = pc;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_instr   = out_instr_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (MEM_WORDS=4): vector table plus async-reset sequence.
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_PC(32'h0), .MEM_WORDS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory model: every word carries its own byte address in the low bits.
   assign bus.imem_instr = 32'h1000_0000 + bus.imem_addr;

   typedef struct {
      logic        ready;
      logic        rv;
      logic [31:0] rt;
      logic        en;
      logic        valid;
      logic [31:0] opc;
      logic [31:0] addr;
      logic        halted;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(logic ready, logic rv, logic [31:0] rt, logic en,
                               logic valid, logic [31:0] opc, logic [31:0] addr,
                               logic halted, logic [31:0] cnt);
      vec_t v;
      v.ready = ready; v.rv = rv; v.rt = rt; v.en = en; v.valid = valid;
      v.opc = opc; v.addr = addr; v.halted = halted; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      //             rdy rv  target        en valid out_pc  addr     halt cnt
      vecs[0]  = mk(1, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 0);  // IDLE -> RUN
      vecs[1]  = mk(1, 0, 32'h0,   1, 1, 32'h0, 32'h4,  0, 0);  // first word
      vecs[2]  = mk(1, 0, 32'h0,   1, 1, 32'h4, 32'h8,  0, 1);
      vecs[3]  = mk(0, 0, 32'h0,   0, 1, 32'h4, 32'h8,  0, 1);  // stall x3
      vecs[4]  = mk(0, 0, 32'h0,   0, 1, 32'h4, 32'h8,  0, 1);
      vecs[5]  = mk(0, 0, 32'h0,   0, 1, 32'h4, 32'h8,  0, 1);
      vecs[6]  = mk(1, 0, 32'h0,   1, 1, 32'h8, 32'hC,  0, 2);
      vecs[7]  = mk(1, 0, 32'h0,   1, 1, 32'hC, 32'h10, 0, 3);
      vecs[8]  = mk(1, 0, 32'h0,   1, 0, 32'hC, 32'h10, 1, 4);  // out of range
      vecs[9]  = mk(1, 0, 32'h0,   0, 0, 32'hC, 32'h10, 1, 4);
      vecs[10] = mk(1, 1, 32'h40,  0, 0, 32'hC, 32'h40, 1, 4);  // far target
      vecs[11] = mk(1, 1, 32'h10,  0, 0, 32'hC, 32'h10, 1, 4);  // boundary word 4
      vecs[12] = mk(1, 1, 32'h4,   0, 0, 32'hC, 32'h4,  0, 4);  // leave HALTED
      vecs[13] = mk(1, 0, 32'h0,   1, 1, 32'h4, 32'h8,  0, 4);
      vecs[14] = mk(1, 1, 32'hE,   0, 0, 32'h4, 32'hC,  0, 5);  // redirect + accept
      vecs[15] = mk(1, 0, 32'h0,   1, 1, 32'hC, 32'h10, 0, 5);
      vecs[16] = mk(1, 0, 32'h0,   1, 0, 32'hC, 32'h10, 1, 6);
      vecs[17] = mk(1, 1, 32'h0,   0, 0, 32'hC, 32'h0,  0, 6);
      vecs[18] = mk(1, 0, 32'h0,   1, 1, 32'h0, 32'h4,  0, 6);
      vecs[19] = mk(0, 1, 32'h8,   0, 0, 32'h0, 32'h8,  0, 6);  // redirect while stalled
      vecs[20] = mk(1, 0, 32'h0,   1, 1, 32'h8, 32'hC,  0, 6);

      bus.out_ready       = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_valid",  {31'b0, bus.out_valid}, 32'h0);
      check("reset_en",     {31'b0, bus.imem_en},   32'h0);
      check("reset_halted", {31'b0, bus.halted},    32'h0);
      check("reset_addr",   bus.imem_addr,          32'h0);
      check("reset_count",  bus.fetch_count,        32'h0);
      check("reset_out_pc", bus.out_pc,             32'h0);
      check("reset_instr",  bus.out_instr,          32'h0);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         bus.out_ready       = vecs[i].ready;
         bus.redirect_valid  = vecs[i].rv;
         bus.redirect_target = vecs[i].rt;
         #1;
         check($sformatf("v%0d_en", i), {31'b0, bus.imem_en}, {31'b0, vecs[i].en});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_valid", i),  {31'b0, bus.out_valid}, {31'b0, vecs[i].valid});
         check($sformatf("v%0d_halted", i), {31'b0, bus.halted},    {31'b0, vecs[i].halted});
         check($sformatf("v%0d_addr", i),   bus.imem_addr,          vecs[i].addr);
         check($sformatf("v%0d_count", i),  bus.fetch_count,        vecs[i].cnt);
         if (vecs[i].valid) begin
            check($sformatf("v%0d_out_pc", i), bus.out_pc,    vecs[i].opc);
            check($sformatf("v%0d_instr", i),  bus.out_instr, 32'h1000_0000 + vecs[i].opc);
         end
      end
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;

      // Asynchronous reset between edges while an instruction is held.
      check("pre_async_valid", {31'b0, bus.out_valid}, 32'h1);
      #2 reset = 1'b1;
      #1;
      check("async_valid", {31'b0, bus.out_valid}, 32'h0);
      check("async_addr",  bus.imem_addr,          32'h0);
      check("async_count", bus.fetch_count,        32'h0);
      check("async_en",    {31'b0, bus.imem_en},   32'h0);
      check("async_out_pc", bus.out_pc,            32'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Restart: edge 1 enters RUN, edge 2 presents word 0.
      @(posedge clk);
      #1;
      check("restart_e1_valid", {31'b0, bus.out_valid}, 32'h0);
      @(posedge clk);
      #1;
      check("restart_e2_valid", {31'b0, bus.out_valid}, 32'h1);
      check("restart_e2_pc",    bus.out_pc,             32'h0);
      check("restart_e2_instr", bus.out_instr,          32'h1000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
